// File: rtl/data_memory_hs_pkg.sv
// dmem_pkg: shared types and address decode for the handshaked data memory.
package dmem_pkg;
  localparam int DMEM_MAX_W = 64;
  typedef enum logic [1:0] {OK, MISALIGNED, OUT_OF_RANGE} dmem_err_e;
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DMEM_MAX_W-1:0] rdata;
  } rsp_stage_t;
  typedef struct packed {
    logic [31:0] index;
    dmem_err_e   err;
  } dec_t;
  // Addresses are zero-extended to 64 bits so one decoder serves any ADDR_W.
  function automatic dec_t dmem_decode(input logic [63:0] addr, input int off_w, input int idx_w);
    dec_t d;
    d.index = 32'((addr >> off_w) & ((64'(1) << idx_w) - 64'(1)));
    d.err = (addr & ((64'(1) << off_w) - 64'(1))) != 64'(0) ? MISALIGNED :
            addr >= (64'(1) << (off_w + idx_w)) ? OUT_OF_RANGE : OK;
    return d;
  endfunction
endpackage

// File: rtl/data_memory_hs_if.sv
// data_memory_hs_if: request/response bus between a load/store unit and the data memory.
interface data_memory_hs_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic                rsp_valid;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;
  modport master(output req_valid, req_we, req_addr, req_wdata, req_be,
                 input req_ready, rsp_valid, rsp_err, rsp_rdata);
  modport slave(input req_valid, req_we, req_addr, req_wdata, req_be,
                output req_ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

// File: rtl/data_memory_hs_rsp_pipe.sv
// dmem_rsp_pipe: RD_LAT-deep response shift register, cleared by async reset.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(parameter int RD_LAT = 1) (
  input  logic       clk,
  input  logic       reset,
  input  rsp_stage_t stg_i,
  output rsp_stage_t stg_o
);
  rsp_stage_t stg_q [RD_LAT];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= stg_i;
      for (int i = 1; i < RD_LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end
  assign stg_o = stg_q[RD_LAT-1];
endmodule

// File: rtl/data_memory_hs.sv
// data_memory_hs: pipelined byte-enable data memory with error responses and a debug port.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  data_memory_hs_if.slave          bus,
  input  logic                     dbg_we,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic [DATA_W-1:0]        dbg_rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  dec_t              dec;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              acc;
  rsp_stage_t        stg_d;
  rsp_stage_t        stg_o;
  logic              unused_bits;
  assign bus.req_ready = !reset && !dbg_we;
  always_comb begin
    dec   = dmem_decode(64'(bus.req_addr[ADDR_W-1:0]), OFF_W, IDX_W);
    idx   = dec.index[IDX_W-1:0];
    err   = dec.err != OK;
    acc   = bus.req_valid && bus.req_ready;
    stg_d = '{valid: acc, err: acc && err,
              rdata: (acc && !err && !bus.req_we) ? DMEM_MAX_W'(mem_q[idx]) : '0};
  end
  // Debug writes and requests never coincide: req_ready is low whenever dbg_we is high.
  always_ff @(posedge clk) begin
    if (dbg_we) mem_q[dbg_addr] <= dbg_wdata;
    else if (acc && bus.req_we && !err)
      for (int b = 0; b < NB; b++)
        if (bus.req_be[b]) mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
  end
  dmem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .stg_i (stg_d),
    .stg_o (stg_o)
  );
  assign bus.rsp_valid = stg_o.valid;
  assign bus.rsp_err   = stg_o.err;
  assign bus.rsp_rdata = stg_o.rdata[DATA_W-1:0];
  assign dbg_rdata     = mem_q[dbg_addr];
  assign unused_bits   = ^{dec.index, stg_o.rdata};
endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed test of data_memory_hs at RD_LAT=1 and RD_LAT=3 side by side.
module tb_data_memory_hs;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_we = 0, dbg_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, dbg_wdata = 0;
  logic [3:0]  req_be = 0;
  logic [5:0]  dbg_addr = 0;
  logic [31:0] dbg_rd [2];
  int          e = 0, errs = 0, checks = 0;
  int          exp_edge[$];
  logic [31:0] exp_data[$];
  logic        exp_err[$];
  logic [31:0] pre [6] = '{32'd5, 32'd10, 32'd20, 32'd30, 32'd40, 32'h55};

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int LAT = k == 0 ? 1 : 3;
    data_memory_hs_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    int   ptr = 0;
    logic exp_v;
    assign bus.req_valid = req_valid;
    assign bus.req_we    = req_we;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.req_be    = req_be;
    data_memory_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .RD_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rd[k])
    );
    // Each expected response is due LAT-1 edges after its acceptance edge; reset drops all pending ones.
    always @(negedge clk) begin
      exp_v = !reset && ptr < exp_edge.size() && e == exp_edge[ptr] + LAT - 1;
      chk($sformatf("L%0d req_ready", LAT), 64'(bus.req_ready), 64'(!reset && !dbg_we));
      chk($sformatf("L%0d rsp_valid@%0d", LAT, e), 64'(bus.rsp_valid), 64'(exp_v));
      if (reset) begin
        chk($sformatf("L%0d rst_err", LAT), 64'(bus.rsp_err), 64'(0));
        chk($sformatf("L%0d rst_rdata", LAT), 64'(bus.rsp_rdata), 64'(0));
        ptr = exp_edge.size();
      end else if (exp_v) begin
        chk($sformatf("L%0d rdata#%0d", LAT, ptr), 64'(bus.rsp_rdata), 64'(exp_data[ptr]));
        chk($sformatf("L%0d err#%0d", LAT, ptr), 64'(bus.rsp_err), 64'(exp_err[ptr]));
        ptr++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwrite(input int a, input logic [31:0] d);
    dbg_we = 1; dbg_addr = 6'(a); dbg_wdata = d;
    tick();
    dbg_we = 0;
  endtask

  task automatic dchk(input int a, input logic [31:0] d);
    dbg_addr = 6'(a);
    #1;
    chk($sformatf("L1 dbg[%0d]", a), 64'(dbg_rd[0]), 64'(d));
    chk($sformatf("L3 dbg[%0d]", a), 64'(dbg_rd[1]), 64'(d));
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] ed, input logic ee);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    exp_edge.push_back(e + 1); exp_data.push_back(ed); exp_err.push_back(ee);
    tick();
    req_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 5; i++) dwrite(i, pre[i]);
    dwrite(63, 32'hDEADBEEF);
    req(0, 32'h8, 0, 0, 32'h14, 0);
    dchk(2, 32'h14);
    req(1, 32'h0, 32'hAABBCCDD, 4'b0010, 0, 0);
    req(0, 32'h0, 0, 0, 32'h0000CC05, 0);
    req(1, 32'h4, 32'hFFFFFFFF, 4'b0000, 0, 0);
    req(0, 32'h4, 0, 0, 32'd10, 0);
    dwrite(0, 32'd5);
    req(0, 32'h6, 0, 0, 0, 1);
    req(1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 1);
    req(0, 32'hFC, 0, 0, 32'hDEADBEEF, 0);
    req(0, 32'hFF, 0, 0, 0, 1);
    req(0, 32'h100, 0, 0, 0, 1);
    req(0, 32'hFFFFFFFC, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) dchk(i, pre[i]);
    dchk(63, 32'hDEADBEEF);
    req(0, 32'h0, 0, 0, 32'd5, 0);
    req(0, 32'h4, 0, 0, 32'd10, 0);
    req(0, 32'h8, 0, 0, 32'd20, 0);
    req(0, 32'hC, 0, 0, 32'd30, 0);
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    dbg_we = 1; dbg_addr = 6'd5; dbg_wdata = 32'h55;
    tick();
    tick();
    dbg_we = 0;
    exp_edge.push_back(e + 1); exp_data.push_back(32'd40); exp_err.push_back(0);
    tick();
    req_valid = 0;
    dchk(5, 32'h55);
    repeat (4) tick();
    req(0, 32'h0, 0, 0, 32'd5, 0);
    req(0, 32'h4, 0, 0, 32'd10, 0);
    reset = 1;
    repeat (2) tick();
    reset = 0;
    req(0, 32'h8, 0, 0, 32'h14, 0);
    for (int i = 0; i < 6; i++) dchk(i, pre[i]);
    repeat (5) tick();
    chk("L1 drained", 64'(g_lane[0].ptr), 64'(exp_edge.size()));
    chk("L3 drained", 64'(g_lane[1].ptr), 64'(exp_edge.size()));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/data_memory_hs.md
# data_memory_hs

- Parametrised, handshaked data memory. It succeeds the fixed single-cycle data memory used inside `datapath`.
- Adds configurable width, depth and read latency, byte-enable writes, and error responses for misaligned or out-of-range accesses.
- Adds a debug port that preloads and inspects contents without hierarchical references.
- Sits between the processor load/store unit and storage. The same block serves the single-cycle core (`RD_LAT=1`) and later pipelined cores (`RD_LAT>1`).

## Interface

Parameters:
- `DATA_W`, 32, word width in bits; must be a power of two ≥ 8.
- `ADDR_W`, 32, byte-address width.
- `DEPTH`, 64, number of words; must be a power of two.
- `RD_LAT`, 1, request-to-response latency in cycles (legal range 1..4).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts the request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_wdata`  in  `DATA_W`  store data.
- `req_be`  in  `DATA_W/8`  byte enables for stores; ignored for loads.
- `rsp_valid`  out  1  response present (one per accepted request).
- `rsp_rdata`  out  `DATA_W`  load data; 0 for stores and for errors.
- `rsp_err`  out  1  accepted request was misaligned or out of range.
- `dbg_we`  in  1  debug write strobe.
- `dbg_addr`  in  `$clog2(DEPTH)`  debug word index.
- `dbg_wdata`  in  `DATA_W`  debug write data.
- `dbg_rdata`  out  `DATA_W`  combinational read of word `dbg_addr`.

## Operation

- Request acceptance: a request is accepted when `req_valid && req_ready`.
- `req_ready` = `!reset && !dbg_we`. The debug write has priority, and no request is accepted in a cycle with `dbg_we`=1.
- Address decode:
  - `OFF_W = $clog2(DATA_W/8)`.
  - Word index = `req_addr[OFF_W +: $clog2(DEPTH)]`.
  - Misaligned: `req_addr[OFF_W-1:0] != 0`.
  - Out of range: `req_addr >= DEPTH*(DATA_W/8)`.
  - Error = misaligned or out of range.
- Store, no error: each byte lane `i` with `req_be[i]`=1 is written at the acceptance edge. Other lanes are unchanged. `req_be`=0 is legal and writes nothing.
- Store with error: memory is unchanged.
- Load, no error: the word is read at the acceptance edge and carried through the response pipeline.
- Load with error: returns `rsp_rdata`=0.
- Every accepted request produces exactly one response, with `rsp_valid`=1 for one cycle. Stores are acknowledged with `rsp_rdata`=0.
- Responses come out in request order. The block is fully pipelined, so one request per cycle is sustained.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the post-store value.
- Debug write: writes the full word at `dbg_addr` on the clock edge.
- `dbg_rdata` always reflects current contents.
- Reset:
  - Clears all response-pipeline valid bits, plus `rsp_valid`, `rsp_err` and `rsp_rdata`, to 0.
  - Memory contents are NOT reset.
  - Requests in flight at reset assertion are dropped without a response.

## Timing

- A request accepted at edge N produces its response visible after edge N+`RD_LAT-1`. With `RD_LAT`=1, the response is visible in the cycle immediately following acceptance.
- Reset values: `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0. `req_ready`=0 while `reset` is high.
- The first request can be accepted in the first cycle after `reset` deasserts.
- No backpressure on responses: the consumer must take `rsp_*` in the cycle `rsp_valid` is high.
- `dbg_rdata` is combinational from `dbg_addr` and memory state. A debug write at edge N is visible from edge N onward.
- Simultaneous `dbg_we` and `req_valid`: the debug write wins and the request waits with `req_ready`=0. The requester must hold the request stable until it is accepted.

## Structure

- Package `dmem_pkg` holds:
  - the `rsp_stage_t` struct {valid, err, rdata};
  - the `dmem_err_e` enum {OK, MISALIGNED, OUT_OF_RANGE}, used internally to compute `err`;
  - the helper function `dmem_decode(addr)` that returns {index, err}.
- Sub-module `dmem_rsp_pipe`: a shift register of `RD_LAT` `rsp_stage_t` entries with async reset of the valid bits. The top module instantiates it once.
- Storage is an inferred `DATA_W`×`DEPTH` array written per byte lane.

## Test plan

All scenarios use `DATA_W`=32, `DEPTH`=64, and run at `RD_LAT`=1 and `RD_LAT`=3.

1. Preload: debug writes 5, 10, 20, 30, 40 to words 0..4, then load `addr` 0x8. Expected: `rsp_rdata`=0x14, `rsp_err`=0, `RD_LAT` cycles after acceptance. `dbg_rdata` at `dbg_addr`=2 reads 0x14.
2. Byte write: word 0 holds 0x00000005; store `addr` 0x0, `be`=4'b0010, `wdata`=0xAABBCCDD, then load 0x0. Expected: 0x0000CC05. The store response has `rsp_rdata`=0 and `rsp_err`=0.
3. Errors: load 0x6 gives `rsp_err`=1, `rsp_rdata`=0. Store 0x100 with `be`=4'hF gives `rsp_err`=1, and `dbg_rdata` for every word is unchanged.
4. Streaming: loads at 0x0, 0x4, 0x8, 0xC on consecutive cycles. Expected: 4 consecutive responses 5, 10, 20, 30 in order, with no bubbles.
5. Conflict: `dbg_we`=1 for 2 cycles while `req_valid`=1. Expected: `req_ready`=0 for both cycles, the request is accepted in the third cycle, and exactly one response is produced.
6. Reset mid-flight (`RD_LAT`=3): issue 2 loads, then assert `reset` one cycle later. Expected: no `rsp_valid` pulse, all outputs 0 during reset, memory still holds the preloaded values after release.
